// File: rtl/led_pattern_gen_if.sv
// Configuration port of the LED pattern generator: one valid/ready
// transfer writes mode, PWM duty and blink half-period into one channel.
interface led_pattern_gen_if #(
  parameter int N_LEDS      = 4,
  parameter int PWM_BITS    = 8,
  parameter int PERIOD_BITS = 10
);
  localparam int CH_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [CH_W-1:0]        cfg_ch;
  logic [1:0]             cfg_mode;
  logic [PWM_BITS-1:0]    cfg_duty;
  logic [PERIOD_BITS-1:0] cfg_period;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_duty, cfg_period,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_duty, cfg_period,
    output cfg_ready
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator. Each channel is OFF, ON, BLINK
// (half-period counted in prescaler ticks) or PWM (shared free-running
// counter compared against a per-channel duty). All outputs are registered.
module led_pattern_gen #(
  parameter int N_LEDS      = 4,
  parameter int PRESCALE    = 25000,
  parameter int PWM_BITS    = 8,
  parameter int PERIOD_BITS = 10
) (
  input  logic              clk,
  input  logic              rst,
  led_pattern_gen_if.slave  cfg,
  output logic              tick_out,
  output logic [N_LEDS-1:0] led
);
  localparam int CH_W  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int PRE_W = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  logic [PRE_W-1:0]    r_pre;
  logic                r_tick;
  logic [PWM_BITS-1:0] r_pwm;
  logic                r_ready;
  logic                w_accept;

  assign w_accept      = cfg.cfg_valid && r_ready;
  assign cfg.cfg_ready = r_ready;
  assign tick_out      = r_tick;

  // Prescaler: r_tick is high exactly while the count sits at PRESCALE-1,
  // so it is loaded one edge early from the PRESCALE-2 compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      if (r_pre == PRE_W'(PRESCALE - 1)) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
      r_tick <= (r_pre == PRE_W'(PRESCALE - 2));
    end
  end

  // Free-running PWM counter, wraps naturally at 2^PWM_BITS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + PWM_BITS'(1);
    end
  end

  // Handshake: ready drops for exactly one cycle after every accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b1;
    end else begin
      r_ready <= !w_accept;
    end
  end

  for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_ch
    mode_e                  r_mode;
    logic [PWM_BITS-1:0]    r_duty;
    logic [PERIOD_BITS-1:0] r_period;
    logic [PERIOD_BITS-1:0] r_bcnt;
    logic                   r_phase;
    logic                   r_led;
    logic                   w_sel;
    logic [PERIOD_BITS-1:0] w_last;

    // Out-of-range channel numbers never match, so such writes only
    // exercise the handshake.
    assign w_sel  = w_accept && (cfg.cfg_ch == CH_W'(gi));
    // A zero period behaves as one tick per half-period.
    assign w_last = (r_period == '0) ? '0 : (r_period - PERIOD_BITS'(1));
    assign led[gi] = r_led;

    // Channel state: a write takes priority over a coincident tick; the
    // blink counter and phase only move while the channel is in BLINK.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mode   <= MODE_OFF;
        r_duty   <= '0;
        r_period <= '0;
        r_bcnt   <= '0;
        r_phase  <= 1'b0;
      end else if (w_sel) begin
        r_mode   <= mode_e'(cfg.cfg_mode);
        r_duty   <= cfg.cfg_duty;
        r_period <= cfg.cfg_period;
        r_bcnt   <= '0;
        r_phase  <= 1'b1;
      end else if ((r_mode == MODE_BLINK) && r_tick) begin
        if (r_bcnt == w_last) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt  <= r_bcnt + PERIOD_BITS'(1);
        end
      end else begin
        r_bcnt  <= r_bcnt;
        r_phase <= r_phase;
      end
    end

    // LED output register driven from the stored channel state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_led <= 1'b0;
      end else begin
        case (r_mode)
          MODE_OFF:   r_led <= 1'b0;
          MODE_ON:    r_led <= 1'b1;
          MODE_BLINK: r_led <= r_phase;
          MODE_PWM:   r_led <= (r_pwm < r_duty);
          default:    r_led <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised self-checking bench for led_pattern_gen with a behavioural
// model that tracks ticks-since-write per channel and absolute cycle count.
module tb_led_pattern_gen;
  localparam int N  = 5;
  localparam int P  = 4;
  localparam int PB = 4;
  localparam int BB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick_out;
  logic [N-1:0] led;

  int total = 0;
  int bad   = 0;

  led_pattern_gen_if #(.N_LEDS(N), .PWM_BITS(PB), .PERIOD_BITS(BB)) cfg_if ();

  led_pattern_gen #(.N_LEDS(N), .PRESCALE(P), .PWM_BITS(PB), .PERIOD_BITS(BB)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg      (cfg_if),
    .tick_out (tick_out),
    .led      (led)
  );

  always #5 clk = ~clk;

  // Behavioural model
  int           m_e = 0;
  int           m_k    [N];
  int           m_mode [N];
  int           m_duty [N];
  int           m_eff  [N];
  bit           m_ready = 1'b1;
  bit           m_tick  = 1'b0;
  logic [N-1:0] m_led   = '0;
  logic [N-1:0] nl;
  bit           acc;
  bit           tick_pre;

  function automatic bit chan_out(int i, int e);
    case (m_mode[i])
      1:       return 1'b1;
      2:       return ((m_k[i] / m_eff[i]) % 2) == 0;
      3:       return (e % (1 << PB)) < m_duty[i];
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e = 0; m_ready = 1'b1; m_tick = 1'b0; m_led = '0;
      for (int i = 0; i < N; i++) begin
        m_k[i] = 0; m_mode[i] = 0; m_duty[i] = 0; m_eff[i] = 1;
      end
    end else begin
      for (int i = 0; i < N; i++) nl[i] = chan_out(i, m_e);
      tick_pre = (m_e % P) == (P - 1);
      acc = cfg_if.cfg_valid && m_ready;
      for (int i = 0; i < N; i++) begin
        if (acc && (int'(cfg_if.cfg_ch) == i)) begin
          m_mode[i] = int'(cfg_if.cfg_mode);
          m_duty[i] = int'(cfg_if.cfg_duty);
          m_eff[i]  = (cfg_if.cfg_period == 0) ? 1 : int'(cfg_if.cfg_period);
          m_k[i]    = 0;
        end else if (m_mode[i] == 2 && tick_pre) begin
          m_k[i] = m_k[i] + 1;
        end
      end
      m_e++;
      m_tick  = (m_e % P) == (P - 1);
      m_ready = !acc;
      m_led   = nl;
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("led", 32'(led), 32'(m_led));
    check("tick_out", 32'(tick_out), 32'(m_tick));
    check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_ready));
  end

  task automatic wr(int ch, int mode, int duty, int period);
    bit rdy;
    int n;
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = 3'(ch);
    cfg_if.cfg_mode   = 2'(mode);
    cfg_if.cfg_duty   = PB'(duty);
    cfg_if.cfg_period = BB'(period);
    n = 0;
    do begin
      rdy = cfg_if.cfg_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 10);
    if (!rdy) check("wr_timeout", 32'(0), 32'(1));
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    check("ready_drop", 32'(cfg_if.cfg_ready), 32'(0));
  endtask

  function automatic int count_led(int ch, int n);
    return 0;
  endfunction

  int cnt;
  logic [11:0] tpat;

  initial begin
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_mode = '0;
    cfg_if.cfg_duty = '0; cfg_if.cfg_period = '0;
    repeat (3) @(negedge clk);
    check("rst_led", 32'(led), 32'(0));
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'(1));
    check("rst_tick", 32'(tick_out), 32'(0));
    rst = 1'b0;

    // tick_out after edges 3, 7, 11 since release
    tpat = 12'b0100_0100_0100;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check("tick_pos", 32'(tick_out), 32'(tpat[n-1]));
    end

    // ON then OFF with valid held high
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 3'd2; cfg_if.cfg_mode = 2'd1;
    @(negedge clk);
    check("hs_ready0", 32'(cfg_if.cfg_ready), 32'(0));
    cfg_if.cfg_mode = 2'd0;
    @(negedge clk);
    check("hs_on", 32'(led), 32'b00100);
    check("hs_ready1", 32'(cfg_if.cfg_ready), 32'(1));
    @(negedge clk);
    check("hs_ready0b", 32'(cfg_if.cfg_ready), 32'(0));
    cfg_if.cfg_valid = 1'b0;
    @(negedge clk);
    check("hs_off", 32'(led), 32'(0));

    // BLINK period 3: 12 lit / 12 dark
    wr(0, 2, 0, 3);
    repeat (30) @(negedge clk);
    cnt = 0;
    for (int n = 0; n < 24; n++) begin @(negedge clk); cnt += int'(led[0]); end
    check("blink3_duty", 32'(cnt), 32'(12));
    wr(0, 2, 0, 0);
    repeat (10) @(negedge clk);
    cnt = 0;
    for (int n = 0; n < 8; n++) begin @(negedge clk); cnt += int'(led[0]); end
    check("blink0_duty", 32'(cnt), 32'(4));

    // PWM duties 5, 0, 15
    wr(1, 3, 5, 0);
    repeat (20) @(negedge clk);
    cnt = 0;
    for (int n = 0; n < 16; n++) begin @(negedge clk); cnt += int'(led[1]); end
    check("pwm5", 32'(cnt), 32'(5));
    wr(1, 3, 0, 0);
    repeat (3) @(negedge clk);
    cnt = 0;
    for (int n = 0; n < 16; n++) begin @(negedge clk); cnt += int'(led[1]); end
    check("pwm0", 32'(cnt), 32'(0));
    wr(1, 3, 15, 0);
    repeat (3) @(negedge clk);
    cnt = 0;
    for (int n = 0; n < 16; n++) begin @(negedge clk); cnt += int'(led[1]); end
    check("pwm15", 32'(cnt), 32'(15));

    // Write on a tick edge: write wins, so 8 lit cycles with period 2
    cnt = 0;
    while (!tick_out && cnt < 20) begin @(negedge clk); cnt++; end
    check("tick_found", 32'(tick_out), 32'(1));
    wr(0, 2, 0, 2);
    cnt = 0;
    for (int n = 0; n < 8; n++) begin @(negedge clk); cnt += int'(led[0]); end
    check("coll_lit", 32'(cnt), 32'(8));
    @(negedge clk);
    check("coll_dark", 32'(led[0]), 32'(0));

    // Out-of-range channel: handshake only
    wr(7, 1, 0, 0);
    repeat (4) @(negedge clk);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      cfg_if.cfg_valid  = 1'($urandom_range(0, 1));
      cfg_if.cfg_ch     = 3'($urandom_range(0, 7));
      cfg_if.cfg_mode   = 2'($urandom_range(0, 3));
      cfg_if.cfg_duty   = PB'($urandom_range(0, 15));
      cfg_if.cfg_period = BB'($urandom_range(0, 3));
      @(negedge clk);
    end
    cfg_if.cfg_valid = 1'b0;

    // Async reset while ch3 blinks
    wr(3, 2, 0, 1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_led", 32'(led), 32'(0));
    check("arst_ready", 32'(cfg_if.cfg_ready), 32'(1));
    check("arst_tick", 32'(tick_out), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_led", 32'(led), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
